// File: rtl/mtimer_multi.sv
// ---------------------------------------------------------------------------
// mtimer_multi
//
// Machine-timer block: a 64-bit mtime counter advanced by a programmable
// prescaler, plus NUM_CMP compare channels. Each channel is either a RISC-V
// style level interrupt (one-shot) or an auto-reloading periodic timer with
// a sticky, write-1-to-clear pending bit.
//
// Register map (byte addresses, 64-bit words, addr[2:0] ignored):
//   0x00        MTIME       RW, byte-enabled
//   0x08        CTRL        [0] enable, [8+:PRESCALE_W] DIV, [32+k] periodic[k]
//   0x10        STATUS      [k] pending[k], write-1-to-clear, byte-enabled
//   0x20+16k    MTIMECMP_k  RW, byte-enabled
//   0x28+16k    PERIOD_k    RW, byte-enabled
//   Anything else reads 0, writes are dropped.
//
// Ports:
//   clk      single clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   i_req    single-cycle register access request
//   i_we     1 = write, 0 = read (qualified by i_req)
//   i_addr   byte address
//   i_be     byte enables for writes
//   i_wdata  write data
//   o_rdata  registered read data, valid the cycle after a read request
//   o_irq    registered per-channel interrupt
// ---------------------------------------------------------------------------
module mtimer_multi #(
    parameter int NUM_CMP    = 2,
    parameter int PRESCALE_W = 8,
    parameter int ADDR_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [7:0]         i_be,
    input  logic [63:0]        i_wdata,
    output logic [63:0]        o_rdata,
    output logic [NUM_CMP-1:0] o_irq
);

    localparam logic [ADDR_W-1:0] W_MTIME  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] W_CTRL   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_STATUS = ADDR_W'(2);

    // Word index of MTIMECMP_k and PERIOD_k.
    function automatic logic [ADDR_W-1:0] cmp_word(input int k);
        return ADDR_W'(4 + 2 * k);
    endfunction

    function automatic logic [ADDR_W-1:0] per_word(input int k);
        return ADDR_W'(5 + 2 * k);
    endfunction

    // Written bits take new data, the rest keep the old value.
    function automatic logic [63:0] merge(input logic [63:0] old_val,
                                          input logic [63:0] new_val,
                                          input logic [63:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]           mtime;
    logic [PRESCALE_W-1:0] pcnt;
    logic                  ctrl_en;
    logic [PRESCALE_W-1:0] ctrl_div;
    logic [NUM_CMP-1:0]    periodic;
    logic [NUM_CMP-1:0]    pending;
    logic [63:0]           mtimecmp [NUM_CMP];
    logic [63:0]           period   [NUM_CMP];
    logic [NUM_CMP-1:0]    irq;
    logic [63:0]           rdata;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] word_addr;
    logic              wr;
    logic              rd;
    logic              wr_any_be;
    logic [63:0]       wmask;

    assign word_addr = i_addr >> 3;
    assign wr        = i_req & i_we;
    assign rd        = i_req & ~i_we;
    assign wr_any_be = wr & (|i_be);

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            wmask[8*b +: 8] = {8{i_be[b]}};
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and mtime
    // ------------------------------------------------------------------
    logic                  tick;
    logic [63:0]           mtime_nxt;
    logic [PRESCALE_W-1:0] pcnt_nxt;
    logic                  wr_ctrl;

    assign tick    = ctrl_en & (pcnt == ctrl_div);
    assign wr_ctrl = wr & (word_addr == W_CTRL);

    // NOTE: every combinational output gets a default before any branch,
    // otherwise a missed path holds the old value and infers a latch.
    always_comb begin
        mtime_nxt = mtime;
        if (wr_any_be && word_addr == W_MTIME) begin
            // Unwritten bytes keep the old, un-incremented value.
            mtime_nxt = merge(mtime, i_wdata, wmask);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end

        pcnt_nxt = pcnt;
        if (wr_ctrl && i_be[1]) begin
            pcnt_nxt = '0;
        end else if (tick) begin
            pcnt_nxt = '0;
        end else if (ctrl_en) begin
            pcnt_nxt = pcnt + PRESCALE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Compare channels
    // ------------------------------------------------------------------
    logic [NUM_CMP-1:0] match;
    logic [NUM_CMP-1:0] status_clr;
    logic [NUM_CMP-1:0] pending_nxt;
    logic [NUM_CMP-1:0] irq_nxt;
    logic [63:0]        cmp_nxt [NUM_CMP];
    logic [63:0]        per_nxt [NUM_CMP];

    always_comb begin
        status_clr = '0;
        if (wr && word_addr == W_STATUS) begin
            status_clr = i_wdata[NUM_CMP-1:0] & wmask[NUM_CMP-1:0];
        end

        for (int k = 0; k < NUM_CMP; k++) begin
            match[k] = (mtime >= mtimecmp[k]);

            cmp_nxt[k] = mtimecmp[k];
            if (periodic[k] && match[k]) begin
                cmp_nxt[k] = mtimecmp[k] + period[k];
            end
            // A bus write overrides the reload; unwritten bytes fall back
            // to the pre-reload compare, not the reloaded one.
            if (wr_any_be && word_addr == cmp_word(k)) begin
                cmp_nxt[k] = merge(mtimecmp[k], i_wdata, wmask);
            end

            per_nxt[k] = period[k];
            if (wr && word_addr == per_word(k)) begin
                per_nxt[k] = merge(period[k], i_wdata, wmask);
            end

            // A set from a match outranks a same-cycle W1C.
            pending_nxt[k] = (pending[k] & ~status_clr[k]) | (periodic[k] & match[k]);
            irq_nxt[k]     = periodic[k] ? pending_nxt[k] : match[k];
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [63:0] ctrl_rd;
    logic [63:0] rd_val;

    always_comb begin
        ctrl_rd                      = '0;
        ctrl_rd[0]                   = ctrl_en;
        ctrl_rd[8 +: PRESCALE_W]     = ctrl_div;
        ctrl_rd[32 +: NUM_CMP]       = periodic;

        rd_val = '0;
        if (word_addr == W_MTIME) begin
            rd_val = mtime;
        end else if (word_addr == W_CTRL) begin
            rd_val = ctrl_rd;
        end else if (word_addr == W_STATUS) begin
            rd_val[NUM_CMP-1:0] = pending;
        end
        for (int k = 0; k < NUM_CMP; k++) begin
            if (word_addr == cmp_word(k)) begin
                rd_val = mtimecmp[k];
            end
            if (word_addr == per_word(k)) begin
                rd_val = period[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime    <= '0;
            pcnt     <= '0;
            ctrl_en  <= 1'b1;
            ctrl_div <= '0;
            periodic <= '0;
            pending  <= '0;
            irq      <= '0;
            rdata    <= '0;
            // NOTE: the compare/period arrays are architectural registers
            // with defined reset values, so they are reset like any flop
            // rather than left as uninitialised storage.
            for (int k = 0; k < NUM_CMP; k++) begin
                mtimecmp[k] <= '1;
                period[k]   <= '0;
            end
        end else begin
            mtime   <= mtime_nxt;
            pcnt    <= pcnt_nxt;
            pending <= pending_nxt;
            irq     <= irq_nxt;

            if (wr_ctrl) begin
                ctrl_en  <= wmask[0] ? i_wdata[0] : ctrl_en;
                ctrl_div <= (ctrl_div & ~wmask[8 +: PRESCALE_W]) |
                            (i_wdata[8 +: PRESCALE_W] & wmask[8 +: PRESCALE_W]);
                periodic <= (periodic & ~wmask[32 +: NUM_CMP]) |
                            (i_wdata[32 +: NUM_CMP] & wmask[32 +: NUM_CMP]);
            end

            for (int k = 0; k < NUM_CMP; k++) begin
                mtimecmp[k] <= cmp_nxt[k];
                period[k]   <= per_nxt[k];
            end

            if (rd) begin
                rdata <= rd_val;
            end
        end
    end

    assign o_rdata = rdata;
    assign o_irq   = irq;

endmodule
